multiplexer_n_to_1_reg: RTL and testbench
=========================================

# multiplexer_n_to_1_reg

Parametrised N-input, WIDTH-bit multiplexer with a registered output stage and valid/ready handshaking on every input channel and on the output. It selects by external select (mode 0) or by internal round-robin arbitration over valid channels (mode 1). It replaces chains of fixed 2:1 bit-slice muxes wherever several producers share one consumer across a clock boundary, for example writeback-source or operand-source selection in a pipelined datapath.

## Interface
- WIDTH, 3: data width per channel (≥1).
- N, 4: number of input channels (≥2).
- SEL_W, 2: select width; must equal max(1, ceil(log2(N))).

- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = external select via S, 1 = round-robin.
- S  input  SEL_W  channel select, used only in mode 0.
- I  input  N*WIDTH  flat data bus; channel k occupies I[k*WIDTH +: WIDTH].
- I_valid  input  N  channel k presents data.
- I_ready  output  N  channel k's word is accepted this cycle (combinational).
- Y  output  WIDTH  registered output data.
- Y_sel  output  SEL_W  index of the channel that supplied Y.
- Y_valid  output  1  Y/Y_sel hold a word.
- Y_ready  input  1  consumer takes the word this cycle.

## Operation
- There is one output register slot (depth 1). `can_accept = !Y_valid | Y_ready`.
- Grant, mode 0: the grant goes to channel S iff S < N and I_valid[S]. If S ≥ N, nothing is granted and every I_ready is 0.
- Grant, mode 1: the grant goes to the first k with I_valid[k], searching ptr, ptr+1, … wrapping modulo N. If no channel is valid, nothing is granted.
- I_ready[k] = can_accept & (grant == k). At most one bit is set. It must not depend on I_valid of any other channel in mode 0.
- On accept (any I_ready bit = 1):
  - Y ← granted channel's data.
  - Y_sel ← grant.
  - Y_valid ← 1.
- With no accept and Y_ready = 1: Y_valid ← 0. Y and Y_sel keep their last values.
- Round-robin pointer:
  - Updates only on accept in mode 1: ptr ← (grant + 1) mod N. When grant = N-1, ptr wraps to 0.
  - Does not change in mode 0.
  - Is not reset by a mode change.
- Mode or S may change on any cycle. They affect only the current-cycle grant and never modify a word already held in the register.
- Word ordering: Y carries words exactly in accept order. No word is dropped or duplicated.

## Timing
- Reset (rst_n low, asynchronous): Y = 0, Y_sel = 0, Y_valid = 0, ptr = 0. I_ready is 0 while rst_n is low.
- Reset mid-transfer discards any held word. The first accept after release is evaluated on the first clk edge with rst_n high.
- Latency: a word accepted at edge t appears on Y with Y_valid = 1 immediately after edge t, i.e. 1 cycle.
- Throughput: 1 word/cycle while Y_ready stays 1. Simultaneous drain and accept in one cycle is required and must produce no bubble.
- Backpressure: if Y_valid = 1 and Y_ready = 0, then Y, Y_sel and Y_valid are stable and all I_ready are 0.
- I_ready is a combinational function of mode, S, I_valid, ptr, Y_valid and Y_ready. There is no combinational path from I data to any output.

## Test plan
- Reset: assert rst_n = 0 mid-stream with Y_valid = 1 → Y = 0, Y_sel = 0, Y_valid = 0 and I_ready = 0 immediately, without waiting for a clk edge.
- Mode 0, N = 4, WIDTH = 3, Y_ready = 1, S = 2, I_valid = 4'b1111, channel 2 = 3'b101 → I_ready = 4'b0100. After the next edge: Y = 3'b101, Y_sel = 2, Y_valid = 1. Repeat with S = 2 and I_valid[2] = 0 → no accept, Y_valid falls to 0.
- Backpressure: hold Y_ready = 0 for 3 cycles with Y_valid = 1 → Y and Y_sel are unchanged and I_ready = 0. Raise Y_ready with a new valid input → the new word is on Y the next cycle with no idle cycle.
- Round-robin fairness: mode 1, all I_valid = 1, Y_ready = 1 for 8 cycles → Y_sel sequence 0,1,2,3,0,1,2,3.
- Round-robin skip/wrap: mode 1, ptr = 3, I_valid = 4'b0010 → grant 1, then ptr = 2. Next, I_valid = 4'b0001 → grant 0 via wrap.
- Invalid select: N = 3 (SEL_W = 2), mode 0, S = 3, all valid → I_ready = 0 and Y_valid drains to 0. Switch to mode 1 in the same run → grants resume from the preserved ptr.

Source files
------------

// File: rtl/multiplexer_n_to_1_reg.sv
`default_nettype none
// ============================================================================
// Module   : multiplexer_n_to_1_reg
// Purpose  : N-input, WIDTH-bit multiplexer with a single registered output
//            slot and valid/ready handshaking on every input and the output.
//            The source is chosen either by an external select (mode 0) or by
//            a round-robin arbiter over the valid channels (mode 1).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1              rising-edge clock
//   rst_n    in   1              asynchronous active-low reset
//   mode     in   1              0 = select by S, 1 = round-robin
//   S        in   SEL_W          channel select (mode 0 only)
//   I        in   N*WIDTH        flat data bus, channel k at I[k*WIDTH +: WIDTH]
//   I_valid  in   N              channel k presents a word
//   I_ready  out  N              channel k's word is accepted this cycle
//   Y        out  WIDTH          registered output word
//   Y_sel    out  SEL_W          channel that supplied Y
//   Y_valid  out  1              Y / Y_sel hold a word
//   Y_ready  in   1              consumer takes the word this cycle
// ============================================================================
module multiplexer_n_to_1_reg #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   S,
    input  logic [N*WIDTH-1:0] I,
    input  logic [N-1:0]       I_valid,
    output logic [N-1:0]       I_ready,
    output logic [WIDTH-1:0]   Y,
    output logic [SEL_W-1:0]   Y_sel,
    output logic               Y_valid,
    input  logic               Y_ready
);

    localparam logic [SEL_W-1:0] c_last_ch = SEL_W'(N - 1);

    // Output slot and round-robin pointer
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_y_sel;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_ptr;

    // Arbitration
    logic             w_can_accept;
    logic             w_sel_valid;      // mode 0 grant exists
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_rr_valid;       // mode 1 grant exists
    int               w_dist;
    int               w_best_dist;
    logic [SEL_W-1:0] w_grant;
    logic             w_grant_valid;
    logic             w_accept;
    logic [SEL_W-1:0] w_ptr_next;
    logic [WIDTH-1:0] w_grant_data;

    // The slot can take a word when empty or when it is drained this cycle,
    // which gives full throughput without a bubble.
    assign w_can_accept = ~r_y_valid | Y_ready;

    // External select: only I_valid[S] is looked at, so a channel's ready
    // never depends on what the other channels are doing. An S beyond the
    // last channel matches nothing and grants nothing.
    always_comb begin
        w_sel_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (S == SEL_W'(k)) begin
                w_sel_valid = I_valid[k];
            end
        end
    end

    // Round-robin: among valid channels pick the one with the smallest
    // circular distance from the pointer. Distance is (k - ptr) mod N, with
    // r_ptr always < N so no true modulo is needed.
    always_comb begin
        w_rr_grant  = '0;
        w_rr_valid  = 1'b0;
        w_dist      = 0;
        w_best_dist = N;
        for (int k = 0; k < N; k++) begin
            if (SEL_W'(k) >= r_ptr) begin
                w_dist = k - int'(r_ptr);
            end else begin
                w_dist = k + N - int'(r_ptr);
            end
            if (I_valid[k] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_rr_grant  = SEL_W'(k);
                w_rr_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        if (mode) begin
            w_grant       = w_rr_grant;
            w_grant_valid = w_rr_valid;
        end else begin
            w_grant       = S;
            w_grant_valid = w_sel_valid;
        end
    end

    assign w_accept   = w_can_accept & w_grant_valid;
    assign w_ptr_next = (w_grant == c_last_ch) ? '0 : w_grant + SEL_W'(1);

    // Data mux feeds only the register, so I never reaches an output
    // combinationally.
    always_comb begin
        w_grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_grant_data = I[k*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is forced low while reset is held so no producer believes a
    // word was taken by a register that is being cleared.
    generate
        for (genvar k = 0; k < N; k++) begin : g_ready
            assign I_ready[k] = rst_n & w_accept & (w_grant == SEL_W'(k));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y       <= '0;
            r_y_sel   <= '0;
            r_y_valid <= 1'b0;
            r_ptr     <= '0;
        end else if (w_accept) begin
            r_y       <= w_grant_data;
            r_y_sel   <= w_grant;
            r_y_valid <= 1'b1;
            // Pointer advances past the winner only for arbitrated grants;
            // it survives mode changes untouched.
            if (mode) begin
                r_ptr <= w_ptr_next;
            end
        end else if (Y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    assign Y       = r_y;
    assign Y_sel   = r_y_sel;
    assign Y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_multiplexer_n_to_1_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplexer_n_to_1_reg
// Purpose  : Self-checking bench for multiplexer_n_to_1_reg. Drives a 4-input
//            and a 3-input instance and compares them against a behavioural
//            model of the selection rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplexer_n_to_1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 4-channel instance
    logic        mode4, yr4, yv4;
    logic [1:0]  s4, ysel4;
    logic [11:0] i4;
    logic [3:0]  v4, rdy4;
    logic [2:0]  y4;
    // 3-channel instance (select value 3 is out of range)
    logic        mode3, yr3, yv3;
    logic [1:0]  s3, ysel3;
    logic [8:0]  i3;
    logic [2:0]  v3, rdy3;
    logic [2:0]  y3;

    multiplexer_n_to_1_reg #(.WIDTH(3), .N(4), .SEL_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .mode(mode4), .S(s4), .I(i4), .I_valid(v4),
        .I_ready(rdy4), .Y(y4), .Y_sel(ysel4), .Y_valid(yv4), .Y_ready(yr4)
    );
    multiplexer_n_to_1_reg #(.WIDTH(3), .N(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .S(s3), .I(i3), .I_valid(v3),
        .I_ready(rdy3), .Y(y3), .Y_sel(ysel3), .Y_valid(yv3), .Y_ready(yr3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic       m4_v, m3_v;
    logic [2:0] m4_y, m3_y;
    logic [1:0] m4_sel, m3_sel, m4_ptr, m3_ptr;

    // Grant rule: mode 0 takes S if in range and valid; mode 1 scans
    // ptr, ptr+1, ... modulo n for the first valid channel.
    function automatic void model_grant(input int n, input bit md, input int s,
                                        input int v, input int ptr,
                                        output bit gv, output int g);
        int k;
        gv = 1'b0;
        g  = 0;
        if (!md) begin
            if (s < n && ((v >> s) & 1) != 0) begin
                gv = 1'b1;
                g  = s;
            end
        end else begin
            for (int j = 0; j < n; j++) begin
                k = (ptr + j) % n;
                if (!gv && ((v >> k) & 1) != 0) begin
                    gv = 1'b1;
                    g  = k;
                end
            end
        end
    endfunction

    function automatic logic [3:0] exp_ready(input int n, input bit md, input int s,
                                             input int v, input int ptr,
                                             input bit mv, input bit yr);
        bit gv;
        int g;
        model_grant(n, md, s, v, ptr, gv, g);
        if (gv && (!mv || yr)) return 4'(1 << g);
        return 4'b0000;
    endfunction

    function automatic void model_reset();
        m4_v = 1'b0; m4_y = '0; m4_sel = '0; m4_ptr = '0;
        m3_v = 1'b0; m3_y = '0; m3_sel = '0; m3_ptr = '0;
    endfunction

    // One clock: model both instances from the inputs held across the edge,
    // then return at the falling edge where new inputs are driven.
    task automatic advance();
        bit gv4, gv3;
        int g4, g3;
        bit acc4, acc3;
        model_grant(4, mode4, int'(s4), int'(v4), int'(m4_ptr), gv4, g4);
        model_grant(3, mode3, int'(s3), int'(v3), int'(m3_ptr), gv3, g3);
        acc4 = rst_n && gv4 && (!m4_v || yr4);
        acc3 = rst_n && gv3 && (!m3_v || yr3);
        @(posedge clk);
        if (acc4) begin
            m4_y = i4[g4*3 +: 3]; m4_sel = 2'(g4); m4_v = 1'b1;
            if (mode4) m4_ptr = 2'((g4 + 1) % 4);
        end else if (yr4 && rst_n) begin
            m4_v = 1'b0;
        end
        if (acc3) begin
            m3_y = i3[g3*3 +: 3]; m3_sel = 2'(g3); m3_v = 1'b1;
            if (mode3) m3_ptr = 2'((g3 + 1) % 3);
        end else if (yr3 && rst_n) begin
            m3_v = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode4 = 1'b0; s4 = 2'd1; v4 = 4'hF; yr4 = 1'b1; i4 = 12'($urandom);
        mode3 = 1'b0; s3 = 2'd0; v3 = 3'h7; yr3 = 1'b1; i3 = 9'($urandom);
        model_reset();
        @(negedge clk); @(negedge clk); #1;
        n_cmp++; if (yv4 !== 1'b0 || y4 !== 3'd0 || ysel4 !== 2'd0) begin
            n_bad++; $display("FAIL reset_state: Y=%0h sel=%0h valid=%b, want 0/0/0", y4, ysel4, yv4); end
        n_cmp++; if (rdy4 !== 4'b0000 || rdy3 !== 3'b000) begin
            n_bad++; $display("FAIL reset_ready: rdy4=%b rdy3=%b, want zeros", rdy4, rdy3); end
        v3 = 3'b000;
        @(negedge clk); rst_n = 1'b1;
        // Load a word and hold it under backpressure, then reset mid-cycle.
        yr4 = 1'b0; #1;
        n_cmp++; if (rdy4 !== 4'b0010) begin
            n_bad++; $display("FAIL reset_fill_ready: got %b want 0010", rdy4); end
        advance();
        advance();
        n_cmp++; if (yv4 !== 1'b1 || ysel4 !== 2'd1) begin
            n_bad++; $display("FAIL reset_prefill: valid=%b sel=%0d want 1/1", yv4, ysel4); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (yv4 !== 1'b0 || y4 !== 3'd0 || ysel4 !== 2'd0 || rdy4 !== 4'b0000) begin
            n_bad++; $display("FAIL reset_async: Y=%0h sel=%0h valid=%b rdy=%b want 0/0/0/0000",
                              y4, ysel4, yv4, rdy4); end
        @(negedge clk); rst_n = 1'b1;
        v4 = 4'h0; yr4 = 1'b1;
    endtask

    task automatic test_mode0_select();
        mode4 = 1'b0; s4 = 2'd2; v4 = 4'b1111; yr4 = 1'b1;
        i4 = 12'($urandom); i4[8:6] = 3'b101; #1;
        n_cmp++; if (rdy4 !== 4'b0100) begin
            n_bad++; $display("FAIL m0_ready: got %b want 0100", rdy4); end
        advance();
        n_cmp++; if (y4 !== 3'b101 || ysel4 !== 2'd2 || yv4 !== 1'b1) begin
            n_bad++; $display("FAIL m0_output: Y=%b sel=%0d valid=%b want 101/2/1", y4, ysel4, yv4); end
        v4 = 4'b1011; i4 = 12'($urandom); #1;
        n_cmp++; if (rdy4 !== 4'b0000) begin
            n_bad++; $display("FAIL m0_noval_ready: got %b want 0000", rdy4); end
        advance();
        n_cmp++; if (yv4 !== 1'b0 || y4 !== 3'b101 || ysel4 !== 2'd2) begin
            n_bad++; $display("FAIL m0_drain: Y=%b sel=%0d valid=%b want 101/2/0", y4, ysel4, yv4); end
    endtask

    task automatic test_backpressure();
        logic [2:0] w, w2;
        mode4 = 1'b0; s4 = 2'd0; v4 = 4'hF; yr4 = 1'b1; i4 = 12'($urandom);
        w = i4[2:0];
        advance();
        yr4 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            i4 = 12'($urandom); s4 = 2'($urandom_range(0, 3)); v4 = 4'($urandom) | 4'b0001; #1;
            n_cmp++; if (rdy4 !== 4'b0000) begin
                n_bad++; $display("FAIL bp_ready c%0d: got %b want 0000", c, rdy4); end
            advance();
            n_cmp++; if (y4 !== w || ysel4 !== 2'd0 || yv4 !== 1'b1) begin
                n_bad++; $display("FAIL bp_hold c%0d: Y=%0h sel=%0d valid=%b want %0h/0/1",
                                  c, y4, ysel4, yv4, w); end
        end
        yr4 = 1'b1; s4 = 2'd3; v4 = 4'b1000; i4 = 12'($urandom); w2 = i4[11:9]; #1;
        n_cmp++; if (rdy4 !== 4'b1000) begin
            n_bad++; $display("FAIL bp_release_ready: got %b want 1000", rdy4); end
        advance();
        n_cmp++; if (y4 !== w2 || ysel4 !== 2'd3 || yv4 !== 1'b1) begin
            n_bad++; $display("FAIL bp_release: Y=%0h sel=%0d valid=%b want %0h/3/1", y4, ysel4, yv4, w2); end
        v4 = 4'h0;
        advance();
    endtask

    task automatic test_rr_fairness();
        logic [2:0] w;
        mode4 = 1'b1; v4 = 4'hF; yr4 = 1'b1;
        for (int j = 0; j < 8; j++) begin
            i4 = 12'($urandom); w = i4[(j % 4)*3 +: 3]; #1;
            n_cmp++; if (rdy4 !== 4'(1 << (j % 4))) begin
                n_bad++; $display("FAIL rr_ready j%0d: got %b want %b", j, rdy4, 4'(1 << (j % 4))); end
            advance();
            n_cmp++; if (ysel4 !== 2'(j % 4) || y4 !== w || yv4 !== 1'b1) begin
                n_bad++; $display("FAIL rr_seq j%0d: sel=%0d Y=%0h valid=%b want %0d/%0h/1",
                                  j, ysel4, y4, yv4, j % 4, w); end
        end
    endtask

    task automatic test_rr_skip_wrap();
        logic [3:0] vv [4];
        logic [3:0] rr [4];
        vv = '{4'b0100, 4'b0010, 4'b0001, 4'b0101};
        // ptr: 0 -> grant 2 (ptr 3) -> grant 1 (ptr 2) -> wrap to 0 (ptr 1) -> grant 2
        rr = '{4'b0100, 4'b0010, 4'b0001, 4'b0100};
        mode4 = 1'b1; yr4 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            v4 = vv[j]; i4 = 12'($urandom); #1;
            n_cmp++; if (rdy4 !== rr[j]) begin
                n_bad++; $display("FAIL rr_skip j%0d: got %b want %b", j, rdy4, rr[j]); end
            advance();
        end
        v4 = 4'h0;
        advance();
    endtask

    task automatic test_invalid_select();
        mode3 = 1'b1; v3 = 3'b010; yr3 = 1'b1; i3 = 9'($urandom); #1;
        n_cmp++; if (rdy3 !== 3'b010) begin
            n_bad++; $display("FAIL inv_prime: got %b want 010", rdy3); end
        advance();
        mode3 = 1'b0; s3 = 2'd0; v3 = 3'b111; i3 = 9'($urandom);
        advance();
        n_cmp++; if (yv3 !== 1'b1 || ysel3 !== 2'd0) begin
            n_bad++; $display("FAIL inv_load: valid=%b sel=%0d want 1/0", yv3, ysel3); end
        s3 = 2'd3; i3 = 9'($urandom); #1;
        n_cmp++; if (rdy3 !== 3'b000) begin
            n_bad++; $display("FAIL inv_ready: got %b want 000", rdy3); end
        advance();
        n_cmp++; if (yv3 !== 1'b0) begin
            n_bad++; $display("FAIL inv_drain: valid=%b want 0", yv3); end
        mode3 = 1'b1; #1;
        n_cmp++; if (rdy3 !== 3'b100) begin
            n_bad++; $display("FAIL inv_resume: got %b want 100", rdy3); end
        advance();
        n_cmp++; if (ysel3 !== 2'd2 || y3 !== i3[8:6]) begin
            n_bad++; $display("FAIL inv_resume_out: sel=%0d Y=%0h want 2/%0h", ysel3, y3, i3[8:6]); end
        #1;
        n_cmp++; if (rdy3 !== 3'b001) begin
            n_bad++; $display("FAIL inv_wrap: got %b want 001", rdy3); end
        advance();
        v3 = 3'b000;
        advance();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ss [6];
        logic [2:0] w;
        ss = '{2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3};
        mode4 = 1'b0; v4 = 4'hF; yr4 = 1'b1;
        for (int j = 0; j < 6; j++) begin
            s4 = ss[j]; i4 = 12'($urandom); w = i4[int'(ss[j])*3 +: 3]; #1;
            n_cmp++; if (rdy4 !== 4'(1 << ss[j])) begin
                n_bad++; $display("FAIL b2b_ready j%0d: got %b want %b", j, rdy4, 4'(1 << ss[j])); end
            advance();
            n_cmp++; if (yv4 !== 1'b1 || ysel4 !== ss[j] || y4 !== w) begin
                n_bad++; $display("FAIL b2b_out j%0d: valid=%b sel=%0d Y=%0h want 1/%0d/%0h",
                                  j, yv4, ysel4, y4, ss[j], w); end
        end
        v4 = 4'h0;
        advance();
    endtask

    task automatic test_random();
        logic [3:0] e4;
        logic [2:0] e3;
        for (int c = 0; c < 300; c++) begin
            mode4 = 1'($urandom); s4 = 2'($urandom); v4 = 4'($urandom); i4 = 12'($urandom);
            yr4 = ($urandom_range(0, 3) != 0);
            mode3 = 1'($urandom); s3 = 2'($urandom); v3 = 3'($urandom); i3 = 9'($urandom);
            yr3 = ($urandom_range(0, 3) != 0);
            #1;
            e4 = exp_ready(4, mode4, int'(s4), int'(v4), int'(m4_ptr), m4_v, yr4);
            e3 = 3'(exp_ready(3, mode3, int'(s3), int'(v3), int'(m3_ptr), m3_v, yr3));
            n_cmp++; if (rdy4 !== e4 || rdy3 !== e3) begin
                n_bad++; $display("FAIL rand_ready c%0d: rdy4=%b/%b rdy3=%b/%b (got/want)",
                                  c, rdy4, e4, rdy3, e3); end
            advance();
            n_cmp++; if (yv4 !== m4_v || y4 !== m4_y || ysel4 !== m4_sel) begin
                n_bad++; $display("FAIL rand_out4 c%0d: got %b/%0h/%0d want %b/%0h/%0d",
                                  c, yv4, y4, ysel4, m4_v, m4_y, m4_sel); end
            n_cmp++; if (yv3 !== m3_v || y3 !== m3_y || ysel3 !== m3_sel) begin
                n_bad++; $display("FAIL rand_out3 c%0d: got %b/%0h/%0d want %b/%0h/%0d",
                                  c, yv3, y3, ysel3, m3_v, m3_y, m3_sel); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mode0_select();
        test_backpressure();
        test_rr_fairness();
        test_rr_skip_wrap();
        test_invalid_select();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
